// File: rtl/boot_pkg.sv
// boot_pkg: shared states, command bytes and region codes for boot_loader_ctrl.
// BOOT_CHECKSUM_EN adds the CHECK state for the trailing sum byte.
`default_nettype none

package boot_pkg;

`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1
  } state_t;
`endif

  localparam logic [7:0] CMD_BEGIN   = 8'h42;  // 'B'
  localparam logic [7:0] CMD_GO      = 8'h47;  // 'G'
  localparam logic [7:0] CMD_WRITE   = 8'h57;  // 'W'

  localparam logic [3:0] REGION_IMEM = 4'h0;
  localparam logic [3:0] REGION_DMEM = 4'h1;

  localparam int FRAME_BYTES = 8;

endpackage

`default_nettype wire

// File: rtl/boot_loader_ctrl_byte_timeout.sv
// byte_timeout: loadable down-counter; expired pulses on the CYCLES-th enabled cycle
// after the last clear.
`default_nettype none

module byte_timeout #(
  parameter int unsigned CYCLES = 5280
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= W'(CYCLES);
    end else if (enable && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  // clear wins over expiry so a byte arriving on the last cycle still counts
  assign expired = enable && !clear && (cnt == W'(1));

endmodule

`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: framed UART command sequencer writing imem/dmem and gating CPU reset.
// Optional macro BOOT_CHECKSUM_EN appends a mod-256 checksum byte to each W frame.
`default_nettype none

module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5280,
  parameter bit          HOLD_ON_RESET  = 1'b0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  rx_data_in,
  input  logic        rx_valid_in,
  output logic [31:0] mem_addr_out,
  output logic [31:0] mem_data_out,
  output logic        imem_we_out,
  output logic        dmem_we_out,
  output logic        cpu_rst_out,
  output logic        busy_out,
  output logic        error_out,
  output logic [15:0] write_count_out
);

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic [31:0] addr_buf, addr_n;
  logic [31:0] data_buf, data_n;
  logic        commit, abort_err, cmd_begin, cmd_go;
  logic        expired;
  logic [3:0]  region;
  logic        in_range;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum, sum_n;
`endif

  byte_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk_in),
    .rst     (rst_in),
    .clear   (rx_valid_in || (state == ST_IDLE)),
    .enable  (state != ST_IDLE),
    .expired (expired)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      idx      <= '0;
      addr_buf <= '0;
      data_buf <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      addr_buf <= addr_n;
      data_buf <= data_n;
`ifdef BOOT_CHECKSUM_EN
      sum      <= sum_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    addr_n    = addr_buf;
    data_n    = data_buf;
    commit    = 1'b0;
    abort_err = 1'b0;
    cmd_begin = 1'b0;
    cmd_go    = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_n     = sum;
`endif
    case (state)
      ST_IDLE: begin
        if (rx_valid_in) begin
          if (rx_data_in == CMD_BEGIN) cmd_begin = 1'b1;
          if (rx_data_in == CMD_GO)    cmd_go    = 1'b1;
          if (rx_data_in == CMD_WRITE) begin
            state_n = ST_PAYLOAD;
            idx_n   = '0;
`ifdef BOOT_CHECKSUM_EN
            sum_n   = '0;
`endif
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid_in) begin
          idx_n = idx + 3'd1;
`ifdef BOOT_CHECKSUM_EN
          sum_n = sum + rx_data_in;
`endif
          // bytes shift in at the top so the first byte ends up least significant
          if (!idx[2]) addr_n = {rx_data_in, addr_buf[31:8]};
          else         data_n = {rx_data_in, data_buf[31:8]};
          if (idx == 3'(FRAME_BYTES - 1)) begin
`ifdef BOOT_CHECKSUM_EN
            state_n = ST_CHECK;
`else
            state_n = ST_IDLE;
            commit  = 1'b1;
`endif
          end
        end else if (expired) begin
          state_n   = ST_IDLE;
          abort_err = 1'b1;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHECK: begin
        if (rx_valid_in) begin
          state_n = ST_IDLE;
          if (rx_data_in == sum) commit    = 1'b1;
          else                   abort_err = 1'b1;
        end else if (expired) begin
          state_n   = ST_IDLE;
          abort_err = 1'b1;
        end
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  assign region   = addr_n[19:16];
  assign in_range = (region == REGION_IMEM) || (region == REGION_DMEM);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_addr_out    <= '0;
      mem_data_out    <= '0;
      imem_we_out     <= 1'b0;
      dmem_we_out     <= 1'b0;
      cpu_rst_out     <= HOLD_ON_RESET;
      error_out       <= 1'b0;
      write_count_out <= '0;
    end else begin
      mem_addr_out <= (commit && in_range) ? addr_n : 32'h0;
      mem_data_out <= (commit && in_range) ? data_n : 32'h0;
      imem_we_out  <= commit && (region == REGION_IMEM);
      dmem_we_out  <= commit && (region == REGION_DMEM);
      if (cmd_begin)   cpu_rst_out <= 1'b1;
      else if (cmd_go) cpu_rst_out <= 1'b0;
      if (cmd_begin)                             error_out <= 1'b0;
      else if (abort_err || (commit && !in_range)) error_out <= 1'b1;
      if (cmd_begin)                write_count_out <= '0;
      else if (commit && in_range)  write_count_out <= write_count_out + 16'd1;
    end
  end

  assign busy_out = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/boot_loader_ctrl.md
# boot_loader_ctrl

Command sequencer between the UART receiver and the instruction/data RAMs. It parses framed commands from the host byte stream, assembles 32-bit address/data words, and decodes the target region. It issues single-cycle write strobes to imem or dmem and holds the CPU in reset while a program is being loaded. It replaces the ad-hoc byte bridge with a checked, time-limited protocol that also controls the CPU.

## Interface
- `TIMEOUT_CYCLES`, default 5280: max idle cycles between bytes inside a frame before abort (about 16 byte-times at `CLOCKS_PER_BAUD`=33).
- `HOLD_ON_RESET`, default 0: reset value of `cpu_rst_out`. A value of 1 holds the CPU in reset after `rst_in` until a `G` command arrives.
- `clk_in` in 1: single system clock.
- `rst_in` in 1: synchronous, active-high reset.
- `rx_data_in` in 8: received byte from `uart_rx`.
- `rx_valid_in` in 1: one-cycle strobe; `rx_data_in` is valid this cycle.
- `mem_addr_out` out 32: byte address of the write. Consumers slice `[13:2]`.
- `mem_data_out` out 32: write data word.
- `imem_we_out` out 1: one-cycle imem write strobe.
- `dmem_we_out` out 1: one-cycle dmem write strobe (all 4 byte lanes).
- `cpu_rst_out` out 1: CPU reset request.
- `busy_out` out 1: high while a frame is partially received.
- `error_out` out 1: sticky error flag.
- `write_count_out` out 16: number of committed writes since the last `B` command or reset. Wraps at 16'hFFFF to 0.

## Operation
- Commands are single ASCII bytes accepted in IDLE. Any other byte in IDLE is ignored with no error.
  - `B` (begin): set `cpu_rst_out`=1, clear `error_out`, clear `write_count_out`.
  - `G` (go): set `cpu_rst_out`=0.
  - `W` (write): enter PAYLOAD with the byte index cleared to 0.
- PAYLOAD: accepts 8 bytes, little-endian.
  - Bytes 0–3 form the address; bytes 4–7 form the data.
  - Command letters received here are treated as data.
- Region decode on `addr[19:16]`:
  - 0 selects imem.
  - 1 selects dmem.
  - Any other value is out of range: no strobe is issued, `error_out` is set, and the count is not incremented.
- Commit: strobe(s), address, data and count increment are all registered together. The FSM returns to IDLE on the same edge.
- A `W` frame is accepted regardless of `cpu_rst_out`, so live patching is allowed.
- FSM states: IDLE, PAYLOAD, CHECK (present only with the macro). There is no separate commit state.

## Timing
- Reset values:
  - `mem_addr_out`, `mem_data_out` = 0.
  - Both write strobes = 0.
  - `busy_out`, `error_out` = 0.
  - `write_count_out` = 0.
  - `cpu_rst_out` = `HOLD_ON_RESET`.
  - FSM = IDLE.
- Write strobes go high exactly one cycle, in the cycle after the final frame byte's `rx_valid_in`. Address and data are valid in that same cycle and return to 0 afterwards.
- `B` and `G` take effect one cycle after their `rx_valid_in`.
- `busy_out` rises the cycle after `W` and falls the cycle the strobe rises.
- A byte arriving in the strobe cycle is processed normally in IDLE; no byte is ever dropped.
- Timeout:
  - The counter resets on every `rx_valid_in` and counts only outside IDLE.
  - When it reaches `TIMEOUT_CYCLES`: return to IDLE, set `error_out`, issue no strobe, discard the partial frame.
- `rst_in` asserted mid-frame discards the frame and forces all reset values, including `cpu_rst_out`.

## Configuration
- `BOOT_CHECKSUM_EN`
  - Defined: after byte 7 the FSM enters CHECK and expects a 9th byte equal to the mod-256 sum of the 8 payload bytes.
    - Match: commit one cycle after the 9th byte.
    - Mismatch: no strobe, set `error_out`, return to IDLE.
  - Undefined: no CHECK state and no sum logic; commit follows byte 7.

## Structure
- `boot_pkg` contains:
  - the state enum;
  - command byte constants `CMD_BEGIN`, `CMD_GO`, `CMD_WRITE`;
  - region constants `REGION_IMEM`=4'h0 and `REGION_DMEM`=4'h1;
  - `FRAME_BYTES`=8.
- One sub-module: `byte_timeout`, a loadable down-counter with `clear`/`enable` inputs and an `expired` pulse.

## Test plan
- **imem write:** `B`, `W`, 00 01 00 00, EF BE AD DE → `imem_we_out` pulses one cycle with addr 32'h0000_0100 and data 32'hDEAD_BEEF; count=1; `cpu_rst_out`=1.
- **dmem write and go:** `W` with address 32'h0001_0008 and data 32'h1234_5678, then `G` → `dmem_we_out` pulses, `imem_we_out` stays 0, `cpu_rst_out` falls after `G`.
- **Out-of-range address:** `W` with address 32'h0005_0000 → no strobes, `error_out`=1, count unchanged; a subsequent `B` clears `error_out`.
- **Timeout:** `W` plus 3 bytes, then silence for `TIMEOUT_CYCLES` → `error_out`=1 and `busy_out`=0; the next full frame commits correctly.
- **Back-to-back frames:** a second `W` arrives in the strobe cycle of the first → both frames commit and count=2. Also, `rst_in` asserted after byte 5 → no strobe, and all outputs take their reset values.
- **Checksum (`BOOT_CHECKSUM_EN`):** correct sum byte commits; sum+1 → no strobe and `error_out`=1.
